ifu2idu: RTL and testbench

- Fetch-to-decode pipeline register between the fetch stage and the decode stage.
- Captures {pc, pc_next, inst} from fetch with a valid/ready handshake on each side.
- Two-entry skid buffer, so ready toward fetch is registered and does not depend combinationally on decode ready.
- Flushes all held entries on an execute-stage jump.

---
 rtl/ifu2idu_pkg.sv | 35 +++
 rtl/ifu2idu_if.sv | 31 +++
 rtl/ifu2idu_slot.sv | 39 +++
 rtl/ifu2idu.sv | 134 +++++++++++++
 tb/tb_ifu2idu.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/ifu2idu_pkg.sv
// Shared types and constants for the fetch-to-decode pipeline register.
package ifu2idu_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;
  localparam logic [ADDR_W-1:0] ADDR_INIT = 32'h8000_0000;
  localparam logic [INST_W-1:0] INST_NOP  = 32'h0000_0013;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [INST_W-1:0] inst;
  } ifu2idu_entry_t;

  // Occupancy decoded from the slot valid bits; ST_BAD is skid-without-main.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2,
    ST_BAD   = 2'd3
  } ifu2idu_state_e;

  function automatic ifu2idu_entry_t make_entry(
    input logic [ADDR_W-1:0] pc,
    input logic [ADDR_W-1:0] pc_next,
    input logic [INST_W-1:0] inst
  );
    ifu2idu_entry_t e;
    e.pc      = pc;
    e.pc_next = pc_next;
    e.inst    = inst;
    return e;
  endfunction

endpackage

// File: rtl/ifu2idu_if.sv
// Fetch/decode handshake bundle; slave modport is the pipeline register's view.
interface ifu2idu_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32
) ();

  logic                  i_ifu_valid;
  logic                  o_i2d_ready;
  logic [ADDR_WIDTH-1:0] i_ifu_pc;
  logic [ADDR_WIDTH-1:0] i_ifu_pc_next;
  logic [INST_WIDTH-1:0] i_ifu_inst;
  logic                  i_exu_jmp_en;
  logic                  o_i2d_valid;
  logic                  i_idu_ready;
  logic [ADDR_WIDTH-1:0] o_i2d_pc;
  logic [ADDR_WIDTH-1:0] o_i2d_pc_next;
  logic [INST_WIDTH-1:0] o_i2d_inst;

  modport slave (
    input  i_ifu_valid, i_ifu_pc, i_ifu_pc_next, i_ifu_inst,
    input  i_exu_jmp_en, i_idu_ready,
    output o_i2d_ready, o_i2d_valid, o_i2d_pc, o_i2d_pc_next, o_i2d_inst
  );

  modport master (
    output i_ifu_valid, i_ifu_pc, i_ifu_pc_next, i_ifu_inst,
    output i_exu_jmp_en, i_idu_ready,
    input  o_i2d_ready, o_i2d_valid, o_i2d_pc, o_i2d_pc_next, o_i2d_inst
  );

endinterface

// File: rtl/ifu2idu_slot.sv
// One entry register; a cleared slot holds the bubble pattern so it can drive outputs directly.
module ifu2idu_slot
  import ifu2idu_pkg::*;
#(
  parameter ifu2idu_entry_t INIT_DATA = '{pc: ADDR_INIT, pc_next: ADDR_INIT, inst: INST_NOP}
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_load,
  input  logic           i_clear,
  input  ifu2idu_entry_t i_data,
  output logic           o_valid,
  output ifu2idu_entry_t o_data
);

  logic           r_valid;
  ifu2idu_entry_t r_data;

  // Clear wins over load so a flush can never be overridden by an accept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= INIT_DATA;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_data  <= INIT_DATA;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else begin
      r_valid <= r_valid;
      r_data  <= r_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/ifu2idu.sv
// Fetch-to-decode two-entry skid pipeline register with jump flush.
// Optional IFU2IDU_PERF_EN adds stall/flush event counters.
module ifu2idu
  import ifu2idu_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = ADDR_W,
  parameter int unsigned           INST_WIDTH = INST_W,
  parameter logic [ADDR_WIDTH-1:0] ADDR_INIT  = ifu2idu_pkg::ADDR_INIT,
  parameter logic [INST_WIDTH-1:0] INST_NOP   = ifu2idu_pkg::INST_NOP
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst,
  ifu2idu_if.slave    io_bus
`ifdef IFU2IDU_PERF_EN
  ,
  output logic [31:0] o_perf_stall_cnt,
  output logic [31:0] o_perf_flush_cnt
`endif
);

  localparam ifu2idu_entry_t BUBBLE = make_entry(ADDR_INIT, ADDR_INIT, INST_NOP);

  logic           w_main_valid, w_skid_valid;
  ifu2idu_entry_t w_main_data, w_skid_data, w_in_data, w_main_src;
  logic           w_main_load, w_main_clear, w_skid_load, w_skid_clear;
  logic           w_acc, w_deq, w_flush;
  ifu2idu_state_e w_state;

  assign w_in_data = make_entry(io_bus.i_ifu_pc, io_bus.i_ifu_pc_next, io_bus.i_ifu_inst);
  assign w_acc     = io_bus.i_ifu_valid && !w_skid_valid;
  assign w_deq     = w_main_valid && io_bus.i_idu_ready;
  assign w_flush   = io_bus.i_exu_jmp_en;

  // Occupancy decode from the two valid bits.
  always_comb begin
    w_state = ST_EMPTY;
    case ({w_skid_valid, w_main_valid})
      2'b00:   w_state = ST_EMPTY;
      2'b01:   w_state = ST_ONE;
      2'b11:   w_state = ST_FULL;
      default: w_state = ST_BAD;
    endcase
  end

  // Slot control: flush first, then the occupancy-driven move/load/clear.
  always_comb begin
    w_main_load  = 1'b0;
    w_main_clear = 1'b0;
    w_skid_load  = 1'b0;
    w_skid_clear = 1'b0;
    w_main_src   = w_in_data;
    if (w_flush) begin
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else begin
      case (w_state)
        ST_EMPTY: begin
          w_main_load = w_acc;
        end
        ST_ONE: begin
          if (w_acc && w_deq) begin
            w_main_load = 1'b1;
          end else if (w_acc) begin
            w_skid_load = 1'b1;
          end else if (w_deq) begin
            w_main_clear = 1'b1;
          end else begin
            w_main_load = 1'b0;
          end
        end
        ST_FULL: begin
          if (w_deq) begin
            w_main_load  = 1'b1;
            w_main_src   = w_skid_data;
            w_skid_clear = 1'b1;
          end else begin
            w_main_load = 1'b0;
          end
        end
        default: begin
          w_main_clear = 1'b1;
          w_skid_clear = 1'b1;
        end
      endcase
    end
  end

  ifu2idu_slot #(.INIT_DATA(BUBBLE)) u_main (
    .i_clk   (i_sys_clk),
    .i_rst   (i_sys_rst),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_data  (w_main_src),
    .o_valid (w_main_valid),
    .o_data  (w_main_data)
  );

  ifu2idu_slot #(.INIT_DATA(BUBBLE)) u_skid (
    .i_clk   (i_sys_clk),
    .i_rst   (i_sys_rst),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  (w_in_data),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data)
  );

  // Main slot already holds the bubble pattern when empty, so outputs are straight register taps.
  assign io_bus.o_i2d_valid   = w_main_valid;
  assign io_bus.o_i2d_ready   = !w_skid_valid;
  assign io_bus.o_i2d_pc      = w_main_data.pc[ADDR_WIDTH-1:0];
  assign io_bus.o_i2d_pc_next = w_main_data.pc_next[ADDR_WIDTH-1:0];
  assign io_bus.o_i2d_inst    = w_main_data.inst[INST_WIDTH-1:0];

`ifdef IFU2IDU_PERF_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;

  // Event counters wrap naturally at 2^32.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      r_stall_cnt <= (w_main_valid && !io_bus.i_idu_ready) ? r_stall_cnt + 32'd1 : r_stall_cnt;
      r_flush_cnt <= (w_flush && (w_main_valid || w_skid_valid || w_acc)) ?
                     r_flush_cnt + 32'd1 : r_flush_cnt;
    end
  end

  assign o_perf_stall_cnt = r_stall_cnt;
  assign o_perf_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_ifu2idu.sv
// Self-checking bench for ifu2idu: directed scenarios plus randomized traffic vs a FIFO model.
module tb_ifu2idu;

  localparam logic [31:0] INIT_PC = 32'h8000_0000;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [97:0] RST_OUT = {1'b0, 1'b1, INIT_PC, INIT_PC, NOP};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifu2idu_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bus ();

`ifdef IFU2IDU_PERF_EN
  logic [31:0] perf_stall, perf_flush;
`endif

  ifu2idu u_dut (
    .i_sys_clk (clk),
    .i_sys_rst (rst),
    .io_bus    (bus)
`ifdef IFU2IDU_PERF_EN
    ,
    .o_perf_stall_cnt (perf_stall),
    .o_perf_flush_cnt (perf_flush)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] inst;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_stall, m_flush;
  int          pass_cnt  = 0;
  int          total_cnt = 0;

  // Reference: a capacity-2 FIFO; head is shown, bubble when empty.
  function automatic logic [97:0] model_out();
    if (q.size() == 0) return RST_OUT;
    return {1'b1, (q.size() < 2), q[0].pc, q[0].pc_next, q[0].inst};
  endfunction

  function automatic logic [97:0] dut_out();
    return {bus.o_i2d_valid, bus.o_i2d_ready, bus.o_i2d_pc, bus.o_i2d_pc_next, bus.o_i2d_inst};
  endfunction

  task automatic tick(input logic v, input logic [31:0] pc, input logic rdy, input logic jmp);
    ent_t e;
    logic acc, deq;
    e.pc = pc; e.pc_next = pc + 32'd4; e.inst = $urandom;
    bus.i_ifu_valid = v; bus.i_ifu_pc = e.pc; bus.i_ifu_pc_next = e.pc_next;
    bus.i_ifu_inst = e.inst; bus.i_idu_ready = rdy; bus.i_exu_jmp_en = jmp;
    @(posedge clk);
    acc = v && (q.size() < 2);
    deq = (q.size() > 0) && rdy;
    if (q.size() > 0 && !rdy) m_stall = m_stall + 32'd1;
    if (jmp && (q.size() > 0 || acc)) m_flush = m_flush + 32'd1;
    if (jmp) q.delete();
    else begin
      if (deq) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    #1;
  endtask

  task automatic do_reset();
    bus.i_ifu_valid = 1'b0; bus.i_idu_ready = 1'b0; bus.i_exu_jmp_en = 1'b0;
    bus.i_ifu_pc = 32'd0; bus.i_ifu_pc_next = 32'd0; bus.i_ifu_inst = 32'd0;
    rst = 1'b1;
    q.delete(); m_stall = 32'd0; m_flush = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (dut_out() !== RST_OUT) $display("FAIL reset_val got=%h exp=%h", dut_out(), RST_OUT);
    else pass_cnt++;
    tick(1'b0, 32'd0, 1'b0, 1'b0);
    total_cnt++;
    if (dut_out() !== RST_OUT) $display("FAIL reset_idle got=%h exp=%h", dut_out(), RST_OUT);
    else pass_cnt++;
  endtask

  task automatic test_stream();
    logic [31:0] pcs [3];
    pcs[0] = 32'h8000_0000; pcs[1] = 32'h8000_0004; pcs[2] = 32'h8000_0008;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, pcs[i], 1'b1, 1'b0);
      total_cnt++;
      if (bus.o_i2d_valid !== 1'b1 || bus.o_i2d_pc !== pcs[i])
        $display("FAIL stream_pc%0d got v=%b pc=%h exp v=1 pc=%h", i, bus.o_i2d_valid, bus.o_i2d_pc, pcs[i]);
      else pass_cnt++;
      total_cnt++;
      if (dut_out() !== model_out()) $display("FAIL stream_full%0d got=%h exp=%h", i, dut_out(), model_out());
      else pass_cnt++;
    end
    tick(1'b0, 32'd0, 1'b1, 1'b0);
    total_cnt++;
    if (dut_out() !== RST_OUT) $display("FAIL stream_drain got=%h exp=%h", dut_out(), RST_OUT);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset();
    tick(1'b1, 32'h8000_0000, 1'b0, 1'b0);
    tick(1'b1, 32'h8000_0004, 1'b0, 1'b0);
    total_cnt++;
    if (bus.o_i2d_ready !== 1'b0 || bus.o_i2d_pc !== 32'h8000_0000)
      $display("FAIL bp_full got rdy=%b pc=%h exp rdy=0 pc=80000000", bus.o_i2d_ready, bus.o_i2d_pc);
    else pass_cnt++;
    tick(1'b1, 32'h8000_0008, 1'b0, 1'b0);
    total_cnt++;
    if (dut_out() !== model_out()) $display("FAIL bp_hold got=%h exp=%h", dut_out(), model_out());
    else pass_cnt++;
    tick(1'b0, 32'd0, 1'b1, 1'b0);
    total_cnt++;
    if (bus.o_i2d_ready !== 1'b1 || bus.o_i2d_pc !== 32'h8000_0004 || bus.o_i2d_valid !== 1'b1)
      $display("FAIL bp_release got rdy=%b v=%b pc=%h exp rdy=1 v=1 pc=80000004",
               bus.o_i2d_ready, bus.o_i2d_valid, bus.o_i2d_pc);
    else pass_cnt++;
    total_cnt++;
    if (dut_out() !== model_out()) $display("FAIL bp_model got=%h exp=%h", dut_out(), model_out());
    else pass_cnt++;
  endtask

  task automatic test_flush();
    do_reset();
    tick(1'b1, 32'h8000_0000, 1'b0, 1'b0);
    tick(1'b1, 32'h8000_0004, 1'b0, 1'b0);
    tick(1'b1, 32'h8000_0010, 1'b0, 1'b1);
    total_cnt++;
    if (dut_out() !== RST_OUT) $display("FAIL flush_empty got=%h exp=%h", dut_out(), RST_OUT);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 32'd0, 1'b1, 1'b0);
      total_cnt++;
      if (bus.o_i2d_valid !== 1'b0 || bus.o_i2d_pc === 32'h8000_0010)
        $display("FAIL flush_ghost%0d got v=%b pc=%h exp v=0 pc!=80000010", i, bus.o_i2d_valid, bus.o_i2d_pc);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(1'b1, 32'h8000_0020, 1'b0, 1'b0);
    tick(1'b1, 32'h8000_0024, 1'b0, 1'b0);
    total_cnt++;
    if (dut_out() !== model_out()) $display("FAIL arst_pre got=%h exp=%h", dut_out(), model_out());
    else pass_cnt++;
    #3;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (dut_out() !== RST_OUT) $display("FAIL arst_mid got=%h exp=%h", dut_out(), RST_OUT);
    else pass_cnt++;
    q.delete(); m_stall = 32'd0; m_flush = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    tick(1'b0, 32'd0, 1'b1, 1'b0);
    total_cnt++;
    if (dut_out() !== RST_OUT) $display("FAIL arst_after got=%h exp=%h", dut_out(), RST_OUT);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] pc;
    do_reset();
    pc = 32'h8000_1000;
    for (int i = 0; i < 400; i++) begin
      logic v, r, j;
      v = ($urandom_range(3, 0) != 0);
      r = ($urandom_range(2, 0) != 0);
      j = ($urandom_range(15, 0) == 0);
      tick(v, pc, r, j);
      pc = pc + 32'd4;
      total_cnt++;
      if (dut_out() !== model_out()) $display("FAIL rand_c%0d got=%h exp=%h", i, dut_out(), model_out());
      else pass_cnt++;
`ifdef IFU2IDU_PERF_EN
      total_cnt++;
      if (perf_stall !== m_stall || perf_flush !== m_flush)
        $display("FAIL rand_perf%0d got s=%0d f=%0d exp s=%0d f=%0d", i, perf_stall, perf_flush, m_stall, m_flush);
      else pass_cnt++;
`endif
    end
  endtask

`ifdef IFU2IDU_PERF_EN
  task automatic test_perf();
    do_reset();
    total_cnt++;
    if (perf_stall !== 32'd0 || perf_flush !== 32'd0)
      $display("FAIL perf_reset got s=%0d f=%0d exp s=0 f=0", perf_stall, perf_flush);
    else pass_cnt++;
    tick(1'b1, 32'h8000_0000, 1'b0, 1'b0);
    repeat (5) tick(1'b0, 32'd0, 1'b0, 1'b0);
    tick(1'b0, 32'd0, 1'b1, 1'b1);
    total_cnt++;
    if (perf_stall !== 32'd5 || perf_flush !== 32'd1)
      $display("FAIL perf_cnt got s=%0d f=%0d exp s=5 f=1", perf_stall, perf_flush);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
`ifdef IFU2IDU_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
